fifo_wr_arb_ctrl: RTL and testbench
===================================

Name: fifo_wr_arb_ctrl

Overview:
Write-side controller for the async FIFO memory, running entirely in the W_CLK domain.
- Arbitrates round-robin between two write requesters and drives the memory write address, write strobe and write data.
- Keeps the binary/Gray write pointer and generates the registered full flag.
- Compares against the read pointer, which arrives already synchronised into W_CLK.

Parameters:
DATA_WIDTH, 8, width of each write data word
ADDR_WIDTH, 3, memory address width; pointers are ADDR_WIDTH+1 bits
FIFO_DEPTH, 8, number of words; must equal 2**ADDR_WIDTH

Ports:
W_CLK  in  1  write-domain clock
W_RST  in  1  asynchronous active-low reset
REQ0  in  1  requester 0 write request; held until acked
WR_DATA0  in  DATA_WIDTH  requester 0 data
REQ1  in  1  requester 1 write request; held until acked
WR_DATA1  in  DATA_WIDTH  requester 1 data
wq2_rptr  in  ADDR_WIDTH+1  Gray read pointer, already synchronised into W_CLK
ACK0  out  1  requester 0 word accepted this cycle
ACK1  out  1  requester 1 word accepted this cycle
w_inc  out  1  memory write strobe
w_adder  out  ADDR_WIDTH  memory write address
WR_DATA  out  DATA_WIDTH  memory write data (muxed from the granted requester)
w_full  out  1  FIFO full, registered
wptr  out  ADDR_WIDTH+1  Gray write pointer, registered, for the read-domain synchroniser

Behaviour:
- Reset (W_RST low, asynchronous): wbin=0, wptr=0, w_full=0, round-robin priority=requester 0.
- Combinational outputs during reset: ACK0/ACK1/w_inc=0 whenever REQ0/REQ1 are low; w_adder=0.
- Grant (combinational):
  - Only one requester high: that requester wins.
  - Both high: the requester holding priority wins.
- Accept condition: accept = (REQ0|REQ1) & ~w_full.
  - w_inc = accept.
  - ACKx = accept & (granted==x); at most one ACK is high per cycle.
- WR_DATA = data of the granted requester. When neither requester is high, WR_DATA = WR_DATA0 (don't-care, but deterministic).
- w_adder = wbin[ADDR_WIDTH-1:0]. The memory captures WR_DATA at the same W_CLK edge that ACK is sampled; write latency is 0 cycles from accept.
- Pointer update:
  - wbin_next = wbin + accept, modulo 2**(ADDR_WIDTH+1) (natural wrap).
  - wgray_next = wbin_next ^ (wbin_next>>1).
  - wbin and wptr are registered on each edge.
- Full:
  - w_full <= (wgray_next == {~wq2_rptr[ADDR_WIDTH:ADDR_WIDTH-1], wq2_rptr[ADDR_WIDTH-2:0]}).
  - Full asserts on the edge of the write that fills the last slot.
  - Full deasserts on the first edge after wq2_rptr advances.
- Round-robin update: only on an accepted grant, and only when both REQs were high; priority then moves to the non-granted requester. A lone requester does not disturb priority.
- Boundary conditions:
  - Full with requests pending: no ACK, no w_inc, pointers hold, priority holds.
  - A request arriving in the same cycle that full clears is accepted normally.
  - Wrap: wbin rolls from 2**(ADDR_WIDTH+1)-1 to 0 with no glitch on the Gray output; exactly one Gray bit changes per accept.
  - wq2_rptr changing in the same cycle as an accept: the next w_full is computed from the new wq2_rptr and wgray_next.
  - Reset mid-burst: pointers and full clear immediately; a requester still holding REQ is acked at address 0 after reset release.
- Requesters must keep REQx and WR_DATAx stable until ACKx; the block does not store data.

Decomposition:
- Shared package holds:
  - the bin2gray function;
  - PTR_WIDTH = ADDR_WIDTH+1;
  - the requester index constants REQ_0=0 and REQ_1=1.
- Natural sub-module: rr_arb2. Inputs req[1:0], update, priority state. Output one-hot grant. Contains the priority flop.
- Pointer/full logic stays in the top module.

Test Plan:
1. Reset then idle, wq2_rptr=0 → w_full=0, wptr=0, w_adder=0, ACKs low, w_inc low.
2. REQ0 held high, data 0xA0..0xA7, wq2_rptr=0 → 8 consecutive ACK0 at w_adder 0..7.
   - wptr sequence 1,3,2,6,7,5,4,12.
   - w_full=1 after the 8th edge.
   - A 9th request is not acked.
3. From full, set wq2_rptr=1 (one read done) → w_full falls the next edge; the pending REQ0 is acked at w_adder=0 and wptr becomes 13.
4. REQ0 and REQ1 both held high with data 0x11/0x22, FIFO empty → ACKs alternate 0,1,0,1.
   - Memory holds 0x11,0x22,0x11,0x22 at addresses 0..3.
   - Each ACK lasts exactly 1 cycle.
5. Drive 16 writes with wq2_rptr tracking them (never full) → w_adder wraps 7→0, wbin wraps 15→0 (wptr 8→0), every wptr step changes exactly one bit.
6. Pull W_RST low mid-burst at wbin=5 → wptr=0 and w_full=0 asynchronously. After release, the held REQ1 is acked at w_adder=0.

Source files
------------

// File: rtl/fifo_wr_arb_ctrl_pkg.sv
// Shared definitions for the async FIFO write-side controller: pointer widths,
// requester indices and the binary-to-Gray helper.
package fifo_wr_arb_ctrl_pkg;

    localparam int unsigned DEF_ADDR_WIDTH = 3;
    localparam int unsigned PTR_WIDTH      = DEF_ADDR_WIDTH + 1;
    localparam int unsigned GRAY_MAX_W     = 16;

    localparam logic REQ_0 = 1'b0;
    localparam logic REQ_1 = 1'b1;

    // Callers zero-extend into GRAY_MAX_W and cast the result back to their width
    function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] bin);
        return bin ^ (bin >> 1'b1);
    endfunction

endpackage

// File: rtl/fifo_wr_arb_ctrl_rr_arb2.sv
// Two-way round-robin arbiter: one-hot grant, priority flips to the loser
// only after a contested grant is actually accepted.
module rr_arb2
    import fifo_wr_arb_ctrl_pkg::*;
(
    input  logic       W_CLK,
    input  logic       W_RST,
    input  logic [1:0] req,
    input  logic       update,
    output logic [1:0] grant
);

    logic prio_r;

    // One-hot grant from the live requests and the held priority
    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = (prio_r == REQ_1) ? 2'b10 : 2'b01;
            default: grant = 2'b00;
        endcase
    end

    // Priority register, moved to the non-granted requester on a contested accept
    always_ff @(posedge W_CLK or negedge W_RST) begin
        if (!W_RST) begin
            prio_r <= REQ_0;
        end else if (update) begin
            prio_r <= grant[REQ_1] ? REQ_0 : REQ_1;
        end else begin
            prio_r <= prio_r;
        end
    end

endmodule

// File: rtl/fifo_wr_arb_ctrl.sv
// Write-side controller of the async FIFO: arbitrates two writers, drives the
// memory write port and keeps the binary/Gray write pointer and full flag.
module fifo_wr_arb_ctrl
    import fifo_wr_arb_ctrl_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int unsigned FIFO_DEPTH = 8
)
(
    input  logic                  W_CLK,
    input  logic                  W_RST,
    input  logic                  REQ0,
    input  logic [DATA_WIDTH-1:0] WR_DATA0,
    input  logic                  REQ1,
    input  logic [DATA_WIDTH-1:0] WR_DATA1,
    input  logic [ADDR_WIDTH:0]   wq2_rptr,
    output logic                  ACK0,
    output logic                  ACK1,
    output logic                  w_inc,
    output logic [ADDR_WIDTH-1:0] w_adder,
    output logic [DATA_WIDTH-1:0] WR_DATA,
    output logic                  w_full,
    output logic [ADDR_WIDTH:0]   wptr
);

    localparam int unsigned PW       = ADDR_WIDTH + 1;
    localparam int unsigned DEPTH_AW = $clog2(FIFO_DEPTH);

    logic [PW-1:0] wbin_r;
    logic [PW-1:0] wptr_r;
    logic          w_full_r;
    logic [PW-1:0] wbin_next_s;
    logic [PW-1:0] wgray_next_s;
    logic [PW-1:0] rptr_full_s;
    logic          full_next_s;
    logic          accept_s;
    logic          update_s;
    logic [1:0]    req_s;
    logic [1:0]    grant_s;

    assign req_s    = {REQ1, REQ0};
    assign accept_s = (REQ0 | REQ1) & ~w_full_r;
    assign update_s = accept_s & REQ0 & REQ1;

    rr_arb2 u_arb (
        .W_CLK  (W_CLK),
        .W_RST  (W_RST),
        .req    (req_s),
        .update (update_s),
        .grant  (grant_s)
    );

    // The grant is not gated by full so WR_DATA stays steady while writers wait
    assign ACK0    = accept_s & grant_s[REQ_0];
    assign ACK1    = accept_s & grant_s[REQ_1];
    assign w_inc   = accept_s;
    assign w_adder = wbin_r[DEPTH_AW-1:0];
    assign WR_DATA = grant_s[REQ_1] ? WR_DATA1 : WR_DATA0;
    assign wptr    = wptr_r;
    assign w_full  = w_full_r;

    // Next pointer and full flag, full being the read pointer with its two MSBs inverted
    always_comb begin
        wbin_next_s  = wbin_r + {{(PW-1){1'b0}}, accept_s};
        wgray_next_s = PW'(bin2gray(GRAY_MAX_W'(wbin_next_s)));
        rptr_full_s  = {~wq2_rptr[ADDR_WIDTH:ADDR_WIDTH-1], wq2_rptr[ADDR_WIDTH-2:0]};
        full_next_s  = (wgray_next_s == rptr_full_s);
    end

    // Pointer and full registers
    always_ff @(posedge W_CLK or negedge W_RST) begin
        if (!W_RST) begin
            wbin_r   <= {PW{1'b0}};
            wptr_r   <= {PW{1'b0}};
            w_full_r <= 1'b0;
        end else begin
            wbin_r   <= wbin_next_s;
            wptr_r   <= wgray_next_s;
            w_full_r <= full_next_s;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arb_ctrl.sv
// Randomized scoreboard bench for fifo_wr_arb_ctrl: a count-based reference
// model queues per-cycle expectations, a negedge monitor pops and compares.
module tb_fifo_wr_arb_ctrl;
    import fifo_wr_arb_ctrl_pkg::*;

    localparam int DW    = 8;
    localparam int AW    = 3;
    localparam int DEPTH = 8;

    logic          W_CLK;
    logic          W_RST;
    logic          REQ0;
    logic          REQ1;
    logic [DW-1:0] WR_DATA0;
    logic [DW-1:0] WR_DATA1;
    logic [AW:0]   wq2_rptr;
    logic          ACK0;
    logic          ACK1;
    logic          w_inc;
    logic [AW-1:0] w_adder;
    logic [DW-1:0] WR_DATA;
    logic          w_full;
    logic [AW:0]   wptr;

    typedef struct {
        logic          ack0;
        logic          ack1;
        logic          winc;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [AW:0]   wptr;
        logic          full;
    } exp_t;

    exp_t exp_q[$];

    int n_cmp  = 0;
    int n_fail = 0;

    int            wc;
    int            rc;
    int            turn;
    bit            full_m;
    bit            hold[2];
    logic [DW-1:0] dat[2];
    bit            mon_en = 1'b0;
    logic [AW:0]   prev_wptr;

    fifo_wr_arb_ctrl #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .W_CLK    (W_CLK),
        .W_RST    (W_RST),
        .REQ0     (REQ0),
        .WR_DATA0 (WR_DATA0),
        .REQ1     (REQ1),
        .WR_DATA1 (WR_DATA1),
        .wq2_rptr (wq2_rptr),
        .ACK0     (ACK0),
        .ACK1     (ACK1),
        .w_inc    (w_inc),
        .w_adder  (w_adder),
        .WR_DATA  (WR_DATA),
        .w_full   (w_full),
        .wptr     (wptr)
    );

    initial W_CLK = 1'b0;
    always #5 W_CLK = ~W_CLK;

    function automatic logic [PTR_WIDTH-1:0] gray_of(input int n);
        logic [PTR_WIDTH-1:0] b;
        b = PTR_WIDTH'(n % (2 * DEPTH));
        return b ^ (b >> 1);
    endfunction

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h at %0t", name, act, req, $time);
        end
    endtask

    // One cycle of the reference model: drive inputs, predict the cycle, advance counts
    task automatic step(input logic [1:0] mask, input int req_pct, input int rd_pct);
        int   win;
        bit   both;
        bit   acc;
        exp_t e;
        for (int x = 0; x < 2; x++) begin
            if (!hold[x] && mask[x] && int'($urandom_range(99)) < req_pct) begin
                hold[x] = 1'b1;
                dat[x]  = DW'($urandom);
            end
        end
        if (rc < wc && int'($urandom_range(99)) < rd_pct) rc++;
        REQ0     = hold[0];
        REQ1     = hold[1];
        WR_DATA0 = dat[0];
        WR_DATA1 = dat[1];
        wq2_rptr = gray_of(rc);
        both = hold[0] && hold[1];
        if (both)         win = turn;
        else if (hold[0]) win = 0;
        else if (hold[1]) win = 1;
        else              win = -1;
        acc    = (win >= 0) && !full_m;
        e.ack0 = acc && (win == 0);
        e.ack1 = acc && (win == 1);
        e.winc = acc;
        e.addr = AW'(wc % DEPTH);
        e.data = (win == 1) ? dat[1] : dat[0];
        e.wptr = gray_of(wc);
        e.full = full_m;
        exp_q.push_back(e);
        if (acc) begin
            if (both) turn = 1 - win;
            hold[win] = 1'b0;
            wc++;
        end
        full_m = ((wc - rc) == DEPTH);
    endtask

    task automatic run_cycles(input int n, input logic [1:0] mask, input int req_pct, input int rd_pct);
        for (int c = 0; c < n; c++) begin
            @(posedge W_CLK);
            #1;
            step(mask, req_pct, rd_pct);
        end
    endtask

    // Reset in the middle of traffic with requester 1 still holding its request
    task automatic do_reset_mid();
        @(posedge W_CLK);
        #1;
        mon_en  = 1'b0;
        hold[0] = 1'b0;
        REQ0    = 1'b0;
        if (!hold[1]) begin
            hold[1] = 1'b1;
            dat[1]  = DW'($urandom);
        end
        REQ1     = 1'b1;
        WR_DATA1 = dat[1];
        W_RST    = 1'b0;
        #1;
        check("rst_mid_wptr", int'(wptr), 0);
        check("rst_mid_full", int'(w_full), 0);
        check("rst_mid_adder", int'(w_adder), 0);
        wc = 0; rc = 0; turn = 0; full_m = 1'b0;
        wq2_rptr = '0;
        repeat (2) @(posedge W_CLK);
        #1;
        W_RST     = 1'b1;
        prev_wptr = '0;
        mon_en    = 1'b1;
        step(2'b10, 100, 0);
    endtask

    // Scoreboard monitor, sampling mid-cycle
    always @(negedge W_CLK) begin : monitor
        exp_t e;
        if (mon_en) begin
            if (exp_q.size() == 0) begin
                check("sb_underflow", 0, 1);
            end else begin
                e = exp_q.pop_front();
                check("ack0", int'(ACK0), int'(e.ack0));
                check("ack1", int'(ACK1), int'(e.ack1));
                check("w_inc", int'(w_inc), int'(e.winc));
                check("w_full", int'(w_full), int'(e.full));
                check("wptr", int'(wptr), int'(e.wptr));
                check("wr_data", int'(WR_DATA), int'(e.data));
                if (e.winc) check("w_adder", int'(w_adder), int'(e.addr));
                check("gray_step", int'($countones(wptr ^ prev_wptr) <= 1), 1);
                prev_wptr = wptr;
            end
        end
    end

    initial begin
        W_RST = 1'b0; REQ0 = 1'b0; REQ1 = 1'b0;
        WR_DATA0 = '0; WR_DATA1 = '0; wq2_rptr = '0;
        wc = 0; rc = 0; turn = 0; full_m = 1'b0;
        hold[0] = 1'b0; hold[1] = 1'b0; dat[0] = '0; dat[1] = '0;
        prev_wptr = '0;
        repeat (2) @(posedge W_CLK);
        #1;
        check("rst_full", int'(w_full), 0);
        check("rst_wptr", int'(wptr), 0);
        check("rst_adder", int'(w_adder), 0);
        check("rst_ack0", int'(ACK0), 0);
        check("rst_ack1", int'(ACK1), 0);
        check("rst_winc", int'(w_inc), 0);
        W_RST  = 1'b1;
        mon_en = 1'b1;
        step(2'b00, 0, 0);
        run_cycles(2, 2'b00, 0, 0);
        // fill to full with no reads, then free exactly one slot
        run_cycles(11, 2'b01, 100, 0);
        run_cycles(1, 2'b01, 100, 100);
        run_cycles(3, 2'b01, 100, 0);
        // sustained contention with a fast reader
        run_cycles(20, 2'b11, 100, 100);
        for (int p = 0; p < 6; p++) begin
            run_cycles(150, 2'($urandom_range(1, 3)), int'($urandom_range(30, 100)),
                       int'($urandom_range(10, 100)));
        end
        begin
            int guard;
            guard = 0;
            while ((wc % (2 * DEPTH)) != 5 && guard < 100) begin
                run_cycles(1, 2'b10, 100, 100);
                guard++;
            end
            check("reach_wbin5", wc % (2 * DEPTH), 5);
        end
        do_reset_mid();
        run_cycles(60, 2'b11, 80, 60);
        @(negedge W_CLK);
        #1;
        mon_en = 1'b0;
        check("sb_drain", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
